// File: rtl/rst_seq.sv
// Reset sequencer: filters PLL lock, then releases N_CH active-low domain resets in order.
// Optional PLL-lock watchdog is compiled in with `define RST_SEQ_WDOG_EN.
module rst_seq #(
    parameter int N_CH         = 3,
    parameter int STEP_CYC     = 16,
    parameter int LOCK_FILT    = 8,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int PLL_RST_CYC  = 32
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            pll_locked,
    input  logic            sw_rst_req,
    output logic [N_CH-1:0] rstn_out,
    output logic            pll_rst,
    output logic            busy,
    output logic            seq_done,
    output logic [7:0]      lock_loss_cnt
);

    localparam int STEP_W = $clog2(STEP_CYC);
    localparam int FILT_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    localparam int IDX_W  = $clog2(N_CH) + 1;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CH - 1);

    if (N_CH < 1 || N_CH > 16 || STEP_CYC < 2 || LOCK_FILT < 1 ||
        LOCK_TIMEOUT < 1 || PLL_RST_CYC < 1) begin : g_bad_param
        $error("rst_seq: parameter out of range");
    end

    typedef enum logic [1:0] {RESET_ALL, WAIT_LOCK, RELEASE, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q;
    logic               lock_s;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [FILT_W-1:0]  filt_q, filt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_CH-1:0]    rstn_q, rstn_d;
    logic               done_q, done_d;
    logic [7:0]         llc_q, llc_d;
    logic               lock_lost;
    logic               wd_hold;

    assign lock_s = sync_q[1];

    always_ff @(posedge sys_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (sys_rst) begin
            sync_q  <= '0;
            state_q <= RESET_ALL;
            step_q  <= '0;
            filt_q  <= '0;
            idx_q   <= '0;
            rstn_q  <= '0;
            done_q  <= 1'b0;
            llc_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], pll_locked};
            state_q <= state_d;
            step_q  <= step_d;
            filt_q  <= filt_d;
            idx_q   <= idx_d;
            rstn_q  <= rstn_d;
            done_q  <= done_d;
            llc_q   <= llc_d;
        end
    end

    // Lock loss only matters once domains may have been released.
    assign lock_lost = (state_q == RELEASE || state_q == DONE) && !lock_s;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latches are inferred.
        state_d = state_q;
        step_d  = step_q;
        filt_d  = filt_q;
        idx_d   = idx_q;
        rstn_d  = rstn_q;
        done_d  = 1'b0;
        llc_d   = llc_q;

        if (sw_rst_req || lock_lost) begin
            state_d = RESET_ALL;
            step_d  = '0;
            filt_d  = '0;
            idx_d   = '0;
            rstn_d  = '0;
            if (lock_lost && llc_q != 8'hFF) llc_d = llc_q + 8'd1;
        end else begin
            unique case (state_q)
                RESET_ALL: begin
                    rstn_d = '0;
                    if (step_q == STEP_LAST) begin
                        state_d = WAIT_LOCK;
                        step_d  = '0;
                        filt_d  = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (!lock_s || wd_hold) begin
                        filt_d = '0;
                    end else if (filt_q == FILT_LAST) begin
                        state_d = RELEASE;
                        filt_d  = '0;
                        idx_d   = '0;
                        step_d  = '0;
                    end else begin
                        filt_d = filt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (step_q == STEP_LAST) begin
                        rstn_d = rstn_q | (N_CH'(1) << idx_q);
                        step_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                DONE: begin
                end
                default: state_d = RESET_ALL;
            endcase
        end
    end

`ifdef RST_SEQ_WDOG_EN
    localparam int TO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int PR_W = (PLL_RST_CYC > 1) ? $clog2(PLL_RST_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [PR_W-1:0] PR_LAST = PR_W'(PLL_RST_CYC - 1);

    logic [TO_W-1:0] to_q, to_d;
    logic [PR_W-1:0] pr_q, pr_d;
    logic            pll_rst_q, pll_rst_d;

    // Counters only run while staying in WAIT_LOCK; any exit (release, sw request) clears them.
    always_comb begin
        to_d      = to_q;
        pr_d      = pr_q;
        pll_rst_d = pll_rst_q;
        if (state_q == WAIT_LOCK && state_d == WAIT_LOCK) begin
            if (pll_rst_q) begin
                if (pr_q == PR_LAST) begin
                    pll_rst_d = 1'b0;
                    pr_d      = '0;
                    to_d      = '0;
                end else begin
                    pr_d = pr_q + 1'b1;
                end
            end else if (to_q == TO_LAST) begin
                pll_rst_d = 1'b1;
                to_d      = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end else begin
            to_d      = '0;
            pr_d      = '0;
            pll_rst_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            to_q      <= '0;
            pr_q      <= '0;
            pll_rst_q <= 1'b0;
        end else begin
            to_q      <= to_d;
            pr_q      <= pr_d;
            pll_rst_q <= pll_rst_d;
        end
    end

    assign wd_hold = pll_rst_q;
    assign pll_rst = pll_rst_q;
`else
    assign wd_hold = 1'b0;
    assign pll_rst = 1'b0;
`endif

    assign rstn_out      = rstn_q;
    assign busy          = (state_q != DONE);
    assign seq_done      = done_q;
    assign lock_loss_cnt = llc_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: directed vector table, hand-built corner sequences and random stimulus,
// all cross-checked every cycle against a phase/elapsed-time reference model.
module tb_rst_seq;

    localparam int N_CH         = 3;
    localparam int STEP_CYC     = 16;
    localparam int LOCK_FILT    = 8;
    localparam int LOCK_TIMEOUT = 64;
    localparam int PLL_RST_CYC  = 32;

    logic            sys_clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic            pll_locked = 1'b1;
    logic            sw_rst_req = 1'b0;
    logic [N_CH-1:0] rstn_out;
    logic            pll_rst;
    logic            busy;
    logic            seq_done;
    logic [7:0]      lock_loss_cnt;

    rst_seq #(
        .N_CH(N_CH), .STEP_CYC(STEP_CYC), .LOCK_FILT(LOCK_FILT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT), .PLL_RST_CYC(PLL_RST_CYC)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pll_locked(pll_locked),
        .sw_rst_req(sw_rst_req), .rstn_out(rstn_out), .pll_rst(pll_rst),
        .busy(busy), .seq_done(seq_done), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: phase plus elapsed cycles; released channels follow from elapsed/STEP_CYC.
    typedef enum {P_RESET, P_WAIT, P_REL, P_DONE} phase_t;
    phase_t m_phase = P_RESET;
    int     m_el = 0, m_run = 0, m_loss = 0, m_wt = 0, m_pt = 0;
    bit     m_done = 0, m_pulse = 0;
    bit [1:0] m_lk = '0;

    function automatic logic [31:0] pack(logic [N_CH-1:0] r, logic p, logic b, logic d, logic [7:0] c);
        return 32'({r, p, b, d, c});
    endfunction

    function automatic logic [N_CH-1:0] m_rstn();
        int k = 0;
        if (m_phase == P_DONE) k = N_CH;
        else if (m_phase == P_REL) k = m_el / STEP_CYC;
        return N_CH'((1 << k) - 1);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        bit     ls, lost;
        phase_t pw;
        if (sys_rst) begin
            m_phase = P_RESET; m_el = 0; m_run = 0; m_loss = 0; m_done = 0;
            m_lk = '0; m_wt = 0; m_pt = 0; m_pulse = 0;
            return;
        end
        ls     = m_lk[1];
        m_lk   = {m_lk[0], pll_locked};
        m_done = 0;
        pw     = m_phase;
        lost   = (m_phase == P_REL || m_phase == P_DONE) && !ls;
        if (sw_rst_req || lost) begin
            if (lost && m_loss < 255) m_loss++;
            m_phase = P_RESET;
            m_el    = 0;
        end else begin
            case (m_phase)
                P_RESET: begin
                    m_el++;
                    if (m_el == STEP_CYC) begin m_phase = P_WAIT; m_run = 0; end
                end
                P_WAIT: begin
                    m_run = (ls && !m_pulse) ? m_run + 1 : 0;
                    if (m_run == LOCK_FILT) begin m_phase = P_REL; m_el = 0; end
                end
                P_REL: begin
                    m_el++;
                    if (m_el == N_CH * STEP_CYC) begin m_phase = P_DONE; m_done = 1; end
                end
                default: ;
            endcase
        end
`ifdef RST_SEQ_WDOG_EN
        if (pw == P_WAIT && m_phase == P_WAIT) begin
            if (m_pulse) begin
                m_pt++;
                if (m_pt == PLL_RST_CYC) begin m_pulse = 0; m_wt = 0; end
            end else begin
                m_wt++;
                if (m_wt == LOCK_TIMEOUT) begin m_pulse = 1; m_pt = 0; end
            end
        end else begin
            m_pulse = 0; m_wt = 0; m_pt = 0;
        end
`else
        if (pw == P_WAIT) m_wt = 0;
`endif
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
    task automatic cyc(input logic r, input logic l, input logic s);
        sys_rst = r; pll_locked = l; sw_rst_req = s;
        @(posedge sys_clk);
        model_edge();
        #1;
        check("model", pack(rstn_out, pll_rst, busy, seq_done, lock_loss_cnt),
              pack(m_rstn(), m_pulse, m_phase != P_DONE, m_done, 8'(m_loss)));
    endtask

    typedef struct {
        logic            rst, lock, sw;
        int              n;
        logic [N_CH-1:0] rstn;
        logic            busy, done;
        logic [7:0]      llc;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, input logic l, input logic s, input int n,
                       input logic [N_CH-1:0] rn, input logic b, input logic d, input logic [7:0] c);
        vec_t v;
        v.rst = r; v.lock = l; v.sw = s; v.n = n; v.rstn = rn; v.busy = b; v.done = d; v.llc = c;
        tbl.push_back(v);
    endtask

    task automatic bound_fail(input string name, input int g);
        n_vec++;
        n_bad++;
        $display("FAIL %s: gave up after %0d cycles, required phase never reached", name, g);
    endtask

    initial begin
        int g;
        logic lk;

        // rst lock sw  n   rstn    busy done llc
        add(1, 1, 0,  5, 3'b000, 1, 0, 0);
        add(0, 1, 0, 15, 3'b000, 1, 0, 0);
        add(0, 1, 0,  1, 3'b000, 1, 0, 0);
        add(0, 1, 0,  7, 3'b000, 1, 0, 0);
        add(0, 1, 0,  1, 3'b000, 1, 0, 0);
        add(0, 1, 0, 15, 3'b000, 1, 0, 0);
        add(0, 1, 0,  1, 3'b001, 1, 0, 0);
        add(0, 1, 0, 16, 3'b011, 1, 0, 0);
        add(0, 1, 0, 15, 3'b011, 1, 0, 0);
        add(0, 1, 0,  1, 3'b111, 0, 1, 0);
        add(0, 1, 0,  1, 3'b111, 0, 0, 0);
        add(0, 0, 0,  2, 3'b111, 0, 0, 0);
        add(0, 0, 0,  1, 3'b000, 1, 0, 1);
        add(0, 1, 0, 15, 3'b000, 1, 0, 1);
        add(0, 1, 0,  1, 3'b000, 1, 0, 1);
        add(0, 1, 0,  8, 3'b000, 1, 0, 1);
        add(0, 1, 0, 16, 3'b001, 1, 0, 1);
        add(0, 1, 1,  1, 3'b000, 1, 0, 1);
        add(0, 1, 0, 16, 3'b000, 1, 0, 1);
        add(0, 1, 0,  8, 3'b000, 1, 0, 1);
        add(0, 1, 0, 47, 3'b011, 1, 0, 1);
        add(0, 1, 0,  1, 3'b111, 0, 1, 1);
        add(0, 1, 1,  1, 3'b000, 1, 0, 1);
        add(0, 1, 0, 44, 3'b001, 1, 0, 1);
        add(1, 1, 0,  1, 3'b000, 1, 0, 0);
        add(0, 1, 0, 72, 3'b111, 0, 1, 0);

        foreach (tbl[i]) begin
            repeat (tbl[i].n) cyc(tbl[i].rst, tbl[i].lock, tbl[i].sw);
            check($sformatf("tbl%0d", i), pack(rstn_out, pll_rst, busy, seq_done, lock_loss_cnt),
                  pack(tbl[i].rstn, 1'b0, tbl[i].busy, tbl[i].done, tbl[i].llc));
        end

        // Lock glitch when the filter has counted to 5: release slips by 6 cycles.
        cyc(0, 1, 1);
        repeat (16) cyc(0, 1, 0);
        check("glitch_wait", {busy, rstn_out}, {1'b1, 3'b000});
        repeat (3) cyc(0, 1, 0);
        cyc(0, 0, 0);
        repeat (25) cyc(0, 1, 0);
        check("glitch_hold", {busy, rstn_out}, {1'b1, 3'b000});
        cyc(0, 1, 0);
        check("glitch_rel", {rstn_out, lock_loss_cnt}, {3'b001, 8'd0});

        // 300 lock losses in RELEASE: counter must saturate.
        for (int i = 0; i < 300; i++) begin
            g = 0;
            while (m_phase != P_REL && g < 200) begin cyc(0, 1, 0); g++; end
            if (g >= 200) bound_fail("sat_wait", g);
            repeat (3) cyc(0, 0, 0);
        end
        check("sat_cnt", {24'd0, lock_loss_cnt}, 32'd255);
        check("sat_rstn", {busy, rstn_out}, {1'b1, 3'b000});

        // Random stimulus in epochs of different lock stability.
        lk = 1'b1;
        for (int e = 0; e < 4; e++) begin
            for (int c = 0; c < 1000; c++) begin
                if (lk) lk = ($urandom_range(0, (e % 2) ? 300 : 40) != 0);
                else    lk = ($urandom_range(0, 3) == 0);
                cyc($urandom_range(0, 799) == 0, lk, $urandom_range(0, 149) == 0);
            end
        end

`ifdef RST_SEQ_WDOG_EN
        // Watchdog: 64 cycles of no lock, then a 32-cycle pll_rst pulse, repeating every 96.
        cyc(0, 0, 1);
        g = 0;
        while (m_phase != P_WAIT && g < 100) begin cyc(0, 0, 0); g++; end
        if (g >= 100) bound_fail("wd_wait", g);
        repeat (63) cyc(0, 0, 0);
        check("wd_pre", {31'd0, pll_rst}, 32'd0);
        cyc(0, 0, 0);
        check("wd_rise", {31'd0, pll_rst}, 32'd1);
        repeat (31) cyc(0, 0, 0);
        check("wd_high", {31'd0, pll_rst}, 32'd1);
        cyc(0, 0, 0);
        check("wd_fall", {31'd0, pll_rst}, 32'd0);
        repeat (63) cyc(0, 0, 0);
        check("wd_gap", {31'd0, pll_rst}, 32'd0);
        cyc(0, 0, 0);
        check("wd_rise2", {31'd0, pll_rst}, 32'd1);
        repeat (12) cyc(0, 1, 0);
        check("wd_filter_held", {pll_rst, busy, rstn_out}, {1'b1, 1'b1, 3'b000});
        cyc(0, 1, 1);
        check("wd_abort", {31'd0, pll_rst}, 32'd0);
        repeat (72) cyc(0, 1, 0);
        check("wd_relock", {pll_rst, busy, seq_done, rstn_out}, {1'b0, 1'b0, 1'b1, 3'b111});
`else
        // Without the watchdog, WAIT_LOCK waits indefinitely and pll_rst never asserts.
        cyc(0, 0, 1);
        repeat (300) cyc(0, 0, 0);
        check("no_wdog", {pll_rst, busy, rstn_out}, {1'b0, 1'b1, 3'b000});
        repeat (80) cyc(0, 1, 0);
        check("no_wdog_rel", {pll_rst, busy, rstn_out}, {1'b0, 1'b0, 3'b111});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
